// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory port between
// the core (C) and the debug/loader port (D). At most one command issues per
// grant and at most one read is outstanding. Read-valid goes only to the owner
// of the outstanding read.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on contention the port not granted most recently wins
//   undefined -> fixed priority, core always wins contention
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | port free; a request may issue
// ST_RD_WAIT | read outstanding; r_lat_cnt counts down to the data cycle
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [2:0]        c_funct3,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
    $fatal(1, "mem_port_arbiter: READ_LATENCY %0d outside 1..7", READ_LATENCY);
  end

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_lat_cnt;
  logic [2:0]  w_lat_cnt_nxt;
  logic        r_owner_d;
  logic        w_owner_d_nxt;

  logic        w_rd_done;
  logic        w_can_issue;
  logic        w_issue;
  logic        w_win_d;
  logic        w_win_we;

  // The data cycle of a read is also an issue slot, so reads can stream.
  assign w_rd_done   = (r_state == ST_RD_WAIT) && (r_lat_cnt == 3'd1);
  assign w_can_issue = (r_state == ST_IDLE) || w_rd_done;
  assign w_issue     = w_can_issue && (c_req || d_req);
  assign w_win_we    = w_win_d ? d_we : c_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_prio_d;

  assign w_win_d = d_req && (!c_req || r_prio_d);

  // Priority pointer: after every issue, the other port is favoured next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio_d <= 1'b0;
    end else if (w_issue) begin
      r_prio_d <= !w_win_d;
    end
  end
`else
  assign w_win_d = d_req && !c_req;
`endif

  // State register with the latency down-counter and read owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 3'd0;
      r_owner_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_owner_d <= w_owner_d_nxt;
    end
  end

  // Next state: a read issue (re)loads the counter; writes never wait.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_owner_d_nxt = r_owner_d;
    if (w_issue && !w_win_we) begin
      w_state_nxt   = ST_RD_WAIT;
      w_lat_cnt_nxt = LAT_INIT;
      w_owner_d_nxt = w_win_d;
    end else if (r_state == ST_RD_WAIT) begin
      if (w_rd_done) begin
        w_state_nxt   = ST_IDLE;
        w_lat_cnt_nxt = 3'd0;
      end else begin
        w_lat_cnt_nxt = r_lat_cnt - 3'd1;
      end
    end
  end

  // Outputs: grants and memory command from the winner, valid to the owner.
  always_comb begin
    c_gnt      = w_issue && !w_win_d;
    d_gnt      = w_issue && w_win_d;
    mem_addr   = (w_issue && w_win_d) ? d_addr   : c_addr;
    mem_wdata  = (w_issue && w_win_d) ? d_wdata  : c_wdata;
    mem_funct3 = (w_issue && w_win_d) ? d_funct3 : c_funct3;
    mem_wren   = w_issue && w_win_we;
    c_rvalid   = w_rd_done && !r_owner_d;
    d_rvalid   = w_rd_done && r_owner_d;
    busy       = (r_state == ST_RD_WAIT);
  end

  assign c_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (READ_LATENCY 1, 2, 3) share one
// stimulus; each test resets and checks the instance with the latency it needs.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
  logic [2:0]  c_funct3, d_funct3;

  logic        c_gnt_o    [1:3];
  logic        c_rvalid_o [1:3];
  logic [31:0] c_rdata_o  [1:3];
  logic        d_gnt_o    [1:3];
  logic        d_rvalid_o [1:3];
  logic [31:0] d_rdata_o  [1:3];
  logic [31:0] mem_addr_o [1:3];
  logic [31:0] mem_wdata_o[1:3];
  logic        mem_wren_o [1:3];
  logic [2:0]  mem_f3_o   [1:3];
  logic        busy_o     [1:3];

  for (genvar k = 1; k <= 3; k++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(k)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_funct3  (c_funct3),
      .c_gnt     (c_gnt_o[k]),
      .c_rvalid  (c_rvalid_o[k]),
      .c_rdata   (c_rdata_o[k]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_funct3  (d_funct3),
      .d_gnt     (d_gnt_o[k]),
      .d_rvalid  (d_rvalid_o[k]),
      .d_rdata   (d_rdata_o[k]),
      .mem_addr  (mem_addr_o[k]),
      .mem_wdata (mem_wdata_o[k]),
      .mem_wren  (mem_wren_o[k]),
      .mem_funct3(mem_f3_o[k]),
      .mem_rdata (mem_rdata),
      .busy      (busy_o[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drv(input logic creq, input logic cwe, input logic [31:0] caddr,
                     input logic dreq, input logic dwe, input logic [31:0] daddr);
    c_req  = creq;
    c_we   = cwe;
    c_addr = caddr;
    d_req  = dreq;
    d_we   = dwe;
    d_addr = daddr;
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    c_wdata   = 32'h1111_1111;
    d_wdata   = 32'h2222_2222;
    c_funct3  = 3'b010;
    d_funct3  = 3'b001;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [31:0] rdata;
    logic        e_cg, e_dg, e_wr, e_crv, e_drv, e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Contention-free single-port traffic on the READ_LATENCY=1 instance.
    vecs[0]  = '{1'b0, 1'b0, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
    vecs[1]  = '{1'b1, 1'b0, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40};
    vecs[2]  = '{1'b0, 1'b0, 32'h44,  1'b0, 1'b0, 32'h0,   32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104};
    vecs[5]  = '{1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   32'h5A5A_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200};
    vecs[6]  = '{1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h80,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80};
    vecs[9]  = '{1'b0, 1'b0, 32'h8,   1'b0, 1'b0, 32'h0,   32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8};
    vecs[10] = '{1'b0, 1'b0, 32'hC,   1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC};

    do_reset();
    #1;
    chk("reset.busy", busy_o[1], 1'b0);
    chk("reset.c_rvalid", c_rvalid_o[1], 1'b0);
    chk("reset.d_rvalid", d_rvalid_o[1], 1'b0);
    chk("reset.mem_wren", mem_wren_o[1], 1'b0);

    for (int i = 0; i < 11; i++) begin
      cyc();
      drv(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr);
      mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d.c_gnt", i),    c_gnt_o[1],    vecs[i].e_cg);
      chk($sformatf("v%0d.d_gnt", i),    d_gnt_o[1],    vecs[i].e_dg);
      chk($sformatf("v%0d.mem_wren", i), mem_wren_o[1], vecs[i].e_wr);
      chk($sformatf("v%0d.c_rvalid", i), c_rvalid_o[1], vecs[i].e_crv);
      chk($sformatf("v%0d.d_rvalid", i), d_rvalid_o[1], vecs[i].e_drv);
      chk($sformatf("v%0d.busy", i),     busy_o[1],     vecs[i].e_busy);
      chk($sformatf("v%0d.mem_addr", i), mem_addr_o[1], vecs[i].e_addr);
      if (vecs[i].e_crv) chk($sformatf("v%0d.c_rdata", i), c_rdata_o[1], vecs[i].rdata);
      if (vecs[i].e_drv) chk($sformatf("v%0d.d_rdata", i), d_rdata_o[1], vecs[i].rdata);
    end

    // Reset asserted while a core read is outstanding (latency 2).
    do_reset();
    cyc(); drv(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0); #1;
    chk("t1.c_gnt", c_gnt_o[2], 1'b1);
    cyc(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t1.busy_before", busy_o[2], 1'b1);
    #2 reset = 1'b0; #1;
    chk("t1.busy_in_reset", busy_o[2], 1'b0);
    chk("t1.c_rvalid_in_reset", c_rvalid_o[2], 1'b0);
    chk("t1.c_gnt_in_reset", c_gnt_o[2], 1'b0);
    chk("t1.d_gnt_in_reset", d_gnt_o[2], 1'b0);
    chk("t1.mem_wren_in_reset", mem_wren_o[2], 1'b0);
    cyc(); reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk($sformatf("t1.c_rvalid_after%0d", k), c_rvalid_o[2], 1'b0);
      chk($sformatf("t1.busy_after%0d", k), busy_o[2], 1'b0);
    end

    // Single core read, latency 2.
    do_reset();
    cyc(); drv(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0); #1;
    chk("t2.c_gnt0", c_gnt_o[2], 1'b1);
    chk("t2.mem_addr0", mem_addr_o[2], 32'h40);
    chk("t2.busy0", busy_o[2], 1'b0);
    cyc(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t2.busy1", busy_o[2], 1'b1);
    chk("t2.c_rvalid1", c_rvalid_o[2], 1'b0);
    cyc(); mem_rdata = 32'hCAFE_0002; #1;
    chk("t2.busy2", busy_o[2], 1'b1);
    chk("t2.c_rvalid2", c_rvalid_o[2], 1'b1);
    chk("t2.c_rdata2", c_rdata_o[2], 32'hCAFE_0002);
    cyc(); #1;
    chk("t2.busy3", busy_o[2], 1'b0);
    chk("t2.c_rvalid3", c_rvalid_o[2], 1'b0);

    // Debug write then core read of the same word, latency 2.
    do_reset();
    cyc(); d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100); #1;
    chk("t3.d_gnt", d_gnt_o[2], 1'b1);
    chk("t3.mem_wren", mem_wren_o[2], 1'b1);
    chk("t3.mem_addr", mem_addr_o[2], 32'h100);
    chk("t3.mem_wdata", mem_wdata_o[2], 32'hDEAD_BEEF);
    chk("t3.mem_funct3", mem_f3_o[2], 3'b010);
    chk("t3.busy_wr", busy_o[2], 1'b0);
    cyc(); drv(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0); #1;
    chk("t3.c_gnt", c_gnt_o[2], 1'b1);
    chk("t3.mem_wren_rd", mem_wren_o[2], 1'b0);
    cyc(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t3.d_rvalid1", d_rvalid_o[2], 1'b0);
    chk("t3.mem_wren1", mem_wren_o[2], 1'b0);
    cyc(); mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t3.c_rvalid", c_rvalid_o[2], 1'b1);
    chk("t3.c_rdata", c_rdata_o[2], 32'hDEAD_BEEF);
    chk("t3.d_rvalid2", d_rvalid_o[2], 1'b0);

    // Both ports hold read requests, latency 1: one issue per cycle.
    do_reset();
    begin
      logic prev_d;
      logic exp_d;
      prev_d = 1'b0;
      for (int k = 0; k < 6; k++) begin
        cyc(); drv(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'h500); mem_rdata = 32'(k); #1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (k % 2) == 1;
`else
        exp_d = 1'b0;
`endif
        chk($sformatf("t4.c_gnt%0d", k), c_gnt_o[1], !exp_d);
        chk($sformatf("t4.d_gnt%0d", k), d_gnt_o[1], exp_d);
        chk($sformatf("t4.c_rvalid%0d", k), c_rvalid_o[1], (k > 0) && !prev_d);
        chk($sformatf("t4.d_rvalid%0d", k), d_rvalid_o[1], (k > 0) && prev_d);
        prev_d = exp_d;
      end
      cyc(); drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500); #1;
      chk("t4.d_gnt_after_drop", d_gnt_o[1], 1'b1);
      chk("t4.c_gnt_after_drop", c_gnt_o[1], 1'b0);
      chk("t4.mem_addr_after_drop", mem_addr_o[1], 32'h500);
    end

    // Back-to-back core reads, latency 3: issue every 3 cycles.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(); drv(1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 32'h0); mem_rdata = 32'h7700 + 32'(k); #1;
      chk($sformatf("t5.c_gnt%0d", k), c_gnt_o[3], (k % 3) == 0);
      chk($sformatf("t5.c_rvalid%0d", k), c_rvalid_o[3], (k > 0) && ((k % 3) == 0));
      chk($sformatf("t5.busy%0d", k), busy_o[3], k > 0);
    end

    // Request raised then dropped while a read is outstanding, latency 3.
    do_reset();
    cyc(); drv(1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 32'h0); #1;
    chk("t6.c_gnt0", c_gnt_o[3], 1'b1);
    cyc(); drv(1'b1, 1'b1, 32'h704, 1'b0, 1'b0, 32'h0); #1;
    chk("t6.c_gnt1", c_gnt_o[3], 1'b0);
    chk("t6.mem_wren1", mem_wren_o[3], 1'b0);
    chk("t6.busy1", busy_o[3], 1'b1);
    cyc(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    chk("t6.c_gnt2", c_gnt_o[3], 1'b0);
    chk("t6.mem_wren2", mem_wren_o[3], 1'b0);
    cyc(); #1;
    chk("t6.c_rvalid3", c_rvalid_o[3], 1'b1);
    chk("t6.c_gnt3", c_gnt_o[3], 1'b0);
    cyc(); #1;
    chk("t6.busy4", busy_o[3], 1'b0);
    chk("t6.c_rvalid4", c_rvalid_o[3], 1'b0);
    chk("t6.mem_wren4", mem_wren_o[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
